// File: rtl/cpu_pkg.sv
// Shared decode-side constants and types for the 32 x 64-bit register array.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 32;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd31;

  // A write-back only ever matters for a real (non-zero) register index.
  function automatic logic wb_hits(input logic en, input reg_idx_t wb_addr, input reg_idx_t addr);
    return en && (wb_addr == addr) && (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/operand_select.sv
// Combinational operand mux: zero register, then same-cycle write-back bypass, then array read.
module operand_select
  import cpu_pkg::*;
(
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  reg_idx_t                     addr,
  input  logic                         wb_en,
  input  reg_idx_t                     wb_addr,
  input  word_t                        wb_data,
  output word_t                        sel
);

  always_comb begin
    sel = regs[addr];
    if (addr == ZERO_REG) begin
      sel = '0;
    end else if (wb_hits(wb_en, wb_addr, addr)) begin
      sel = wb_data;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID/EX operand register: selects two bypassed operands and registers them with flush/stall,
// refreshing held operands when write-back lands on them during a stall.
module id_operand_stage
  import cpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic                         valid_in,
  input  reg_idx_t                     addr_a,
  input  reg_idx_t                     addr_b,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         wb_en,
  input  reg_idx_t                     wb_addr,
  input  word_t                        wb_data,
  output logic                         valid_out,
  output word_t                        op_a,
  output word_t                        op_b,
  output reg_idx_t                     addr_a_q,
  output reg_idx_t                     addr_b_q
);

  word_t    sel_a, sel_b;
  logic     valid_q, valid_d;
  word_t    op_a_q, op_a_d, op_b_q, op_b_d;
  reg_idx_t addr_a_d, addr_b_d;

  operand_select u_sel_a (
    .regs    (regs),
    .addr    (addr_a),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .sel     (sel_a)
  );

  operand_select u_sel_b (
    .regs    (regs),
    .addr    (addr_b),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .sel     (sel_b)
  );

  // valid_out marks the slot as a real instruction; it is not a handshake and carries no ready.
  always_comb begin
    valid_d  = valid_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    if (flush) begin
      valid_d  = 1'b0;
      op_a_d   = '0;
      op_b_d   = '0;
      addr_a_d = ZERO_REG;
      addr_b_d = ZERO_REG;
    end else if (stall) begin
      // Held operands track write-back even in a bubble so they never go stale.
      if (wb_hits(wb_en, wb_addr, addr_a_q)) op_a_d = wb_data;
      if (wb_hits(wb_en, wb_addr, addr_b_q)) op_b_d = wb_data;
    end else begin
      valid_d  = valid_in;
      op_a_d   = sel_a;
      op_b_d   = sel_b;
      addr_a_d = addr_a;
      addr_b_d = addr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      addr_a_q <= ZERO_REG;
      addr_b_q <= ZERO_REG;
    end else begin
      valid_q  <= valid_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  assign valid_out = valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed plus randomized bench for id_operand_stage with a reference model feeding an expected queue.
module tb_id_operand_stage;
  import cpu_pkg::*;

  localparam int EW = 1 + 2 * DATA_W + 10;

  logic                         clk;
  logic                         reset;
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         valid_in;
  reg_idx_t                     addr_a, addr_b;
  logic                         stall, flush;
  logic                         wb_en;
  reg_idx_t                     wb_addr;
  word_t                        wb_data;
  logic                         valid_out;
  word_t                        op_a, op_b;
  reg_idx_t                     addr_a_q, addr_b_q;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  logic     m_valid;
  word_t    m_a, m_b;
  reg_idx_t m_aa, m_ab;

  id_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .regs      (regs),
    .valid_in  (valid_in),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .stall     (stall),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .valid_out (valid_out),
    .op_a      (op_a),
    .op_b      (op_b),
    .addr_a_q  (addr_a_q),
    .addr_b_q  (addr_b_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t model_sel(input reg_idx_t a);
    if (a == 5'd31) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  // Advance the model with the inputs currently driven, queue the expectation, then clock and compare.
  task automatic step();
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (reset || flush) begin
      m_valid = 1'b0; m_a = '0; m_b = '0; m_aa = 5'd31; m_ab = 5'd31;
    end else if (stall) begin
      if (wb_en && wb_addr == m_aa && m_aa != 5'd31) m_a = wb_data;
      if (wb_en && wb_addr == m_ab && m_ab != 5'd31) m_b = wb_data;
    end else begin
      m_valid = valid_in; m_a = model_sel(addr_a); m_b = model_sel(addr_b);
      m_aa = addr_a; m_ab = addr_b;
    end
    exp_q.push_back({m_valid, m_a, m_b, m_aa, m_ab});
    @(posedge clk);
    #1;
    got = {valid_out, op_a, op_b, addr_a_q, addr_b_q};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        fails++;
        $error("FAIL sb: observed v=%b a=%h b=%h aa=%0d ab=%0d expected v=%b a=%h b=%h aa=%0d ab=%0d",
               got[EW-1], got[EW-2 -: 64], got[73:10], got[9:5], got[4:0],
               e[EW-1], e[EW-2 -: 64], e[73:10], e[9:5], e[4:0]);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
    check({tag, "_op_a"}, op_a, 64'd0);
    check({tag, "_op_b"}, op_b, 64'd0);
    check({tag, "_aa"}, {59'd0, addr_a_q}, 64'd31);
    check({tag, "_ab"}, {59'd0, addr_b_q}, 64'd31);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; addr_a = '0; addr_b = '0;
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_aa = 5'd31; m_ab = 5'd31;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
    #1;
    step();
    step();
    check_reset_vals("reset");

    // 1: plain load
    reset = 1'b0; regs[5] = 64'd8675309; addr_a = 5'd5; addr_b = 5'd0; valid_in = 1'b1;
    step();
    check("t1_op_a", op_a, 64'd8675309);
    check("t1_valid", {63'd0, valid_out}, 64'd1);
    check("t1_aa", {59'd0, addr_a_q}, 64'd5);

    // 2: zero register beats both array content and a write-back to it
    addr_b = 5'd31; regs[31] = 64'hFFFF; wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'h1234;
    step();
    check("t2_op_b", op_b, 64'd0);

    // 3: same-cycle bypass on both ports
    regs[9] = 64'd10; wb_addr = 5'd9; wb_data = 64'd77; addr_a = 5'd9; addr_b = 5'd9;
    step();
    check("t3_op_a", op_a, 64'd77);
    check("t3_op_b", op_b, 64'd77);

    // 4: stall with refresh in the second cycle
    wb_en = 1'b0; regs[3] = 64'd1; addr_a = 5'd3; addr_b = 5'd7;
    step();
    check("t4_load", op_a, 64'd1);
    stall = 1'b1; addr_a = 5'd5; regs[3] = 64'd555;
    step();
    check("t4_c1_op_a", op_a, 64'd1);
    check("t4_c1_valid", {63'd0, valid_out}, 64'd1);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd42;
    step();
    check("t4_c2_op_a", op_a, 64'd42);
    wb_en = 1'b0;
    step();
    check("t4_c3_op_a", op_a, 64'd42);
    check("t4_c3_valid", {63'd0, valid_out}, 64'd1);
    check("t4_c3_aa", {59'd0, addr_a_q}, 64'd3);

    // stall release loads the pending inputs
    stall = 1'b0;
    step();
    check("rel_op_a", op_a, 64'd8675309);

    // 5: flush wins over stall
    stall = 1'b1; flush = 1'b1;
    step();
    check_reset_vals("t5");

    // write-back to the zero register while holding index 31 changes nothing
    flush = 1'b0; wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'hDEAD;
    step();
    check("wbz_op_a", op_a, 64'd0);

    // 6: reset during stall with write-back aimed at the held address
    stall = 1'b0; wb_en = 1'b0; addr_a = 5'd3; regs[3] = 64'd1;
    step();
    check("t6_load", op_a, 64'd1);
    stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd99; reset = 1'b1;
    step();
    check_reset_vals("t6");
    reset = 1'b0; stall = 1'b0; wb_en = 1'b0;

    // randomized mix, checked through the scoreboard
    for (int i = 0; i < 200; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      addr_a   = 5'($urandom_range(0, 31));
      addr_b   = ($urandom_range(0, 3) == 0) ? addr_a : 5'($urandom_range(0, 31));
      stall    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? addr_a : m_aa)
                                             : 5'($urandom_range(0, 31));
      wb_data  = {$urandom, $urandom};
      regs[$urandom_range(0, 31)] = {$urandom, $urandom};
      step();
    end

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side consumer of the 32 x 64-bit register array.
- Selects two source operands by address and bypasses a same-cycle write-back into them.
- Registers the operands into the ID/EX pipeline boundary, with stall and flush control.
- Keeps held operands coherent if write-back updates them while the stage is stalled.

Parameters:
- DATA_W, 64, operand/register width
- NREGS, 32, number of architectural registers
- ZERO_REG, 31, index that always reads as zero

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- regs  input  [NREGS-1:0][DATA_W-1:0]  current register array contents
- valid_in  input  1  decode slot holds a real instruction
- addr_a  input  5  source register A index
- addr_b  input  5  source register B index
- stall  input  1  hold the ID/EX register contents
- flush  input  1  squash the ID/EX register (insert bubble)
- wb_en  input  1  write-back writing the array this cycle
- wb_addr  input  5  write-back destination index
- wb_data  input  DATA_W  write-back data
- valid_out  output  1  ID/EX slot valid
- op_a  output  DATA_W  registered operand A
- op_b  output  DATA_W  registered operand B
- addr_a_q  output  5  registered addr_a (for EX forwarding)
- addr_b_q  output  5  registered addr_b

Behaviour:
- Combinational select, per port X in {a,b}:
  - If addr_X == ZERO_REG, sel_X = 0, regardless of wb_en.
  - Else if wb_en and wb_addr == addr_X, sel_X = wb_data (write-through bypass).
  - Else sel_X = regs[addr_X].
- Sequential update on posedge clk, priority reset > flush > stall > load:
  - reset: valid_out, op_a, op_b = 0; addr_a_q, addr_b_q = 5'd31.
  - flush: valid_out = 0, op_a = op_b = 0, addr_*_q = 5'd31. Flush wins over simultaneous stall.
  - stall: valid_out and addr_*_q hold. Held-operand refresh: if wb_en and wb_addr == addr_X_q and addr_X_q != ZERO_REG, op_X <= wb_data; otherwise op_X holds. The refresh applies regardless of valid_out.
  - load (no reset/flush/stall): valid_out <= valid_in, op_X <= sel_X, addr_X_q <= addr_X.
- Latency: exactly 1 cycle from addr/valid_in to registered outputs.
- addr_a == addr_b: both ports get identical values, including the bypass case.
- wb_addr == ZERO_REG never alters any output.
- Reset asserted mid-stall: outputs clear on that edge; no refresh occurs.
- Stall deasserts: the next edge loads new inputs normally.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, NREGS, ZERO_REG constants.
  - typedef reg_idx_t (logic [4:0]).
  - typedef word_t (logic [DATA_W-1:0]).
- One natural sub-module: operand_select. It is the combinational zero/bypass/array mux, instantiated twice (ports A and B).
- The ID/EX register and refresh logic stay in the top module.

Test Plan:
1. Reset, then regs[5]=64'd8675309, addr_a=5, valid_in=1, no stall/flush. Next edge: op_a=8675309, valid_out=1, addr_a_q=5.
2. addr_b=31 with regs[31] forced to 64'hFFFF, plus wb_en=1, wb_addr=31, wb_data=64'h1234. Next edge: op_b=0.
3. regs[9]=64'd10, wb_en=1, wb_addr=9, wb_data=64'd77, addr_a=addr_b=9. Next edge: op_a=op_b=77.
4. Load op_a from r3=64'd1. Assert stall for 3 cycles; in cycle 2 apply wb_en=1, wb_addr=3, wb_data=64'd42. Required: op_a=1 until that edge, then 42 held. valid_out stays 1 throughout.
5. stall=1 and flush=1 on the same edge. Required: valid_out=0, op_a=op_b=0, addr_*_q=31.
6. Reset asserted during a stall with valid_out=1 and wb to the held address. Required: next edge all outputs at reset values; op_a=0, not wb_data.
